// File: rtl/dvs_aer_event_buffer.sv
// dvs_aer_event_buffer: DVS AER receiver. Runs the 4-phase REQ/ACK handshake with the
// camera, pairs X words with the most recent Y word, stamps each event with a free-running
// cycle counter and queues it in a small FIFO that is drained through the event-bus arbiter.
module dvs_aer_event_buffer #(
    parameter int X_BITS          = 9,
    parameter int Y_BITS          = 9,
    parameter int TS_BITS         = 16,
    parameter int FIFO_DEPTH      = 8,
    parameter int Y_SETTLE_CYCLES = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DROP_ON_FULL    = 1,
    localparam int AW = (X_BITS + 1 > Y_BITS) ? X_BITS + 1 : Y_BITS,
    localparam int EB = TS_BITS + Y_BITS + X_BITS + 1,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] aer,
    input  logic          xsel,
    input  logic          req,
    output logic          ack,
    input  logic          fifo_grant,
    output logic          fifo_req,
    output logic [EB-1:0] fifo_bus_event,
    output logic [CW-1:0] fifo_count,
    output logic [15:0]   drop_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = (Y_SETTLE_CYCLES > 1) ? $clog2(Y_SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(Y_SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {R_IDLE, R_SETTLE, R_STALL, R_ACK} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_GAP} tx_state_t;

    rx_state_t rx_state, rx_next;
    tx_state_t tx_state, tx_next;

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic [SW-1:0]          settle_cnt;
    logic [Y_BITS-1:0]      y_hold;
    logic                   y_valid;
    logic [TS_BITS-1:0]     ts;
    logic [EB-1:0]          live_event;
    logic [EB-1:0]          cap_event;
    logic [EB-1:0]          push_event;
    logic [EB-1:0]          mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic                   full, empty;
    logic                   push, pop, drop, y_load, capture, load_head;

    assign req_s      = req_sync[SYNC_STAGES-1];
    assign full       = (fifo_count == DEPTH_C);
    assign empty      = (fifo_count == '0);
    // aer[X_BITS:0] is already {x, pol}, so it drops straight into the event word
    assign live_event = {ts, y_hold, aer[X_BITS:0]};
    // a stalled X event was captured earlier; push its frozen copy, not the live bus
    assign push_event = (rx_state == R_STALL) ? cap_event : live_event;

    // Synchronise the asynchronous camera request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_sync <= '0;
        else        req_sync <= {req_sync[SYNC_STAGES-2:0], req};
    end

    // RX state register; ack is registered from the next state so it cannot glitch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            ack      <= 1'b0;
        end else begin
            rx_state <= rx_next;
            ack      <= (rx_next == R_ACK);
        end
    end

    // RX next state: Y settle/latch, X capture with push, drop or stall
    always_comb begin
        rx_next = rx_state;
        push    = 1'b0;
        drop    = 1'b0;
        y_load  = 1'b0;
        capture = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (req_s) begin
                    if (xsel) begin
                        capture = 1'b1;
                        rx_next = R_ACK;
                        if (!y_valid) begin
                            drop = 1'b1;
                        end else if (full) begin
                            if (DROP_ON_FULL != 0) drop = 1'b1;
                            else                   rx_next = R_STALL;
                        end else begin
                            push = 1'b1;
                        end
                    end else begin
                        rx_next = R_SETTLE;
                    end
                end
            end
            R_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    y_load  = 1'b1;
                    rx_next = R_ACK;
                end
            end
            R_STALL: begin
                if (!full) begin
                    push    = 1'b1;
                    rx_next = R_ACK;
                end
            end
            R_ACK: begin
                if (!req_s) rx_next = R_IDLE;
            end
            default: rx_next = R_IDLE;
        endcase
    end

    // Count cycles spent waiting for the Y word to settle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     settle_cnt <= '0;
        else if (rx_state == R_SETTLE)  settle_cnt <= settle_cnt + SW'(1);
        else                            settle_cnt <= '0;
    end

    // Y validity survives across events so several X words may share one Y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      y_valid <= 1'b0;
        else if (y_load) y_valid <= 1'b1;
    end

    // Held Y address
    always_ff @(posedge clk) begin
        if (y_load) y_hold <= aer[Y_BITS-1:0];
    end

    // Snapshot of the X event taken at the capture edge, used if the push stalls
    always_ff @(posedge clk) begin
        if (capture) cap_event <= live_event;
    end

    // Free-running timestamp, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else        ts <= ts + TS_BITS'(1);
    end

    // Saturating count of discarded X events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           drop_count <= '0;
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_event;
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // TX state register with registered request and event bus (bus holds while idle)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state       <= T_IDLE;
            fifo_req       <= 1'b0;
            fifo_bus_event <= '0;
        end else begin
            tx_state <= tx_next;
            fifo_req <= (tx_next == T_REQ);
            if (load_head) fifo_bus_event <= mem[rd_ptr];
        end
    end

    // TX next state: present head, pop on grant, then wait for grant to drop
    always_comb begin
        tx_next   = tx_state;
        pop       = 1'b0;
        load_head = 1'b0;
        case (tx_state)
            T_IDLE: begin
                if (!empty) begin
                    load_head = 1'b1;
                    tx_next   = T_REQ;
                end
            end
            T_REQ: begin
                if (fifo_grant) begin
                    pop     = 1'b1;
                    tx_next = T_GAP;
                end
            end
            T_GAP: begin
                if (!fifo_grant) tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

endmodule
